instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 30 +++
 rtl/instr_encoder.sv | 123 ++++++++++++
 tb/tb_instr_encoder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bundle for the instruction encoder.
// master = request source / memory side, slave = encoder.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;
    logic        wr_busy;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [10:0] words;
    logic        done;
    logic        err;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last, wr_busy,
        input  in_ready, wr_en, wr_addr, wr_data, words, done, err
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last, wr_busy,
        output in_ready, wr_en, wr_addr, wr_data, words, done, err
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes MIPS-style instruction requests into 32-bit words, buffers them in a
// small FIFO and streams them into instruction memory from address BASE.
module instr_encoder #(
    parameter logic [31:0] BASE     = 32'h0000_3000,
    parameter int          DEPTH    = 4,
    parameter int          IM_WORDS = 1024
) (
    input logic            clk,
    input logic            reset,
    instr_encoder_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t          state, state_nxt;
    logic            in_ready;
    logic            xfer_p0;
    logic            vld_p0;
    logic [31:0]     enc_p0;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   cnt;
    logic            pop, cap_hit, commit;
    logic [31:0]     addr;
    logic            wr_en_p1;
    logic [31:0]     wr_addr_p1, wr_data_p1;
    logic [10:0]     words;
    logic            err;

    function automatic logic [31:0] encode(input logic [3:0] kind, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [15:0] imm, input logic [25:0] tgt);
        case (kind)
            4'd1:    encode = {6'h00, rs, rt, rd, 5'd0, 6'h21};
            4'd2:    encode = {6'h00, rs, rt, rd, 5'd0, 6'h23};
            4'd3:    encode = {6'h0D, rs, rt, imm};
            4'd4:    encode = {6'h23, rs, rt, imm};
            4'd5:    encode = {6'h2B, rs, rt, imm};
            4'd6:    encode = {6'h04, rs, rt, imm};
            4'd7:    encode = {6'h0F, 5'd0, rt, imm};
            4'd8:    encode = {6'h03, tgt};
            4'd9:    encode = {6'h00, rs, 15'd0, 6'h08};
            default: encode = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic legal(input logic [3:0] kind);
        return kind <= 4'd9;
    endfunction

    // Stage p0: request handshake and combinational encode.
    assign in_ready = ((state == IDLE) || (state == LOAD)) && (cnt < CW'(DEPTH));
    assign xfer_p0  = bus.in_valid && in_ready;
    assign vld_p0   = xfer_p0 && legal(bus.in_kind);
    assign enc_p0   = encode(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd,
                             bus.in_imm, bus.in_target);

    // A pop past the memory capacity still drains the FIFO but never writes.
    assign pop     = (cnt != '0) && !bus.wr_busy;
    assign cap_hit = (words == 11'(IM_WORDS));
    assign commit  = pop && !cap_hit;

    always_ff @(posedge clk) begin
        if (vld_p0) mem[wptr] <= enc_p0;
    end

    // Stage p1: FIFO bookkeeping and registered memory write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            cnt        <= '0;
            addr       <= BASE;
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= BASE;
            wr_data_p1 <= 32'h0;
            words      <= '0;
            err        <= 1'b0;
        end else begin
            if (vld_p0) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
            case ({vld_p0, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            wr_en_p1 <= commit;
            if (commit) begin
                wr_data_p1 <= mem[rptr];
                wr_addr_p1 <= addr;
                addr       <= addr + 32'd4;
                words      <= words + 1'b1;
            end
            if ((xfer_p0 && !legal(bus.in_kind)) || (pop && cap_hit)) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (xfer_p0) state_nxt = bus.in_last ? FLUSH : LOAD;
            LOAD:  if (xfer_p0 && bus.in_last) state_nxt = FLUSH;
            FLUSH: if ((cnt == '0) && !wr_en_p1) state_nxt = DONE;
            DONE:  state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en_p1;
    assign bus.wr_addr  = wr_addr_p1;
    assign bus.wr_data  = wr_data_p1;
    assign bus.words    = words;
    assign bus.done     = (state == DONE);
    assign bus.err      = err;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    instr_encoder_if bus ();
    instr_encoder_if bus4 ();

    instr_encoder dut (.clk(clk), .reset(reset), .bus(bus));
    instr_encoder #(.IM_WORDS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] wq_addr [$];
    logic [31:0] wq_data [$];
    int          wq_cyc  [$];
    int          cnt4 = 0;
    int          nonzero4 = 0;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wq_addr.push_back(bus.wr_addr);
            wq_data.push_back(bus.wr_data);
            wq_cyc.push_back(cyc);
        end
        if (bus4.wr_en === 1'b1) begin
            cnt4 = cnt4 + 1;
            if (bus4.wr_data !== 32'h0) nonzero4 = nonzero4 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        bus.in_valid = 0; bus.in_kind = 0; bus.in_rs = 0; bus.in_rt = 0; bus.in_rd = 0;
        bus.in_imm = 0; bus.in_target = 0; bus.in_last = 0; bus.wr_busy = 0;
        bus4.in_valid = 0; bus4.in_kind = 0; bus4.in_rs = 0; bus4.in_rt = 0; bus4.in_rd = 0;
        bus4.in_imm = 0; bus4.in_target = 0; bus4.in_last = 0; bus4.wr_busy = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic last);
        bit got = 0;
        bus.in_kind = k; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
        bus.in_imm = imm; bus.in_target = tgt; bus.in_last = last; bus.in_valid = 1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                got = 1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 0;
        bus.in_last = 0;
        chk("send_accepted", 32'(got), 32'd1);
    endtask

    task automatic wait_writes(input string tag, input int n);
        for (int i = 0; i < 100 && wq_data.size() < n; i++) @(negedge clk);
        chk(tag, 32'(wq_data.size()), 32'(n));
    endtask

    initial begin
        int first_acc;
        apply_reset();

        // Reset state.
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_addr", bus.wr_addr, 32'h3000);
        chk("rst_wr_data", bus.wr_data, 32'h0);
        chk("rst_words", 32'(bus.words), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);

        // ori then addu, latency check.
        send(4'd3, 5'd0, 5'd1, 5'd9, 16'h1234, 26'h3FF_FFFF, 1'b0);
        first_acc = acc_cyc;
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h155_5555, 1'b0);
        wait_writes("t35_count", 2);
        if (wq_data.size() >= 2) begin
            chk("t35_d0", wq_data[0], 32'h3401_1234);
            chk("t35_a0", wq_addr[0], 32'h3000);
            chk("t35_d1", wq_data[1], 32'h0022_1821);
            chk("t35_a1", wq_addr[1], 32'h3004);
            chk("t35_latency", 32'(wq_cyc[0]), 32'(first_acc + 2));
        end
        chk("t35_words", 32'(bus.words), 32'd2);

        // lui / jal / jr with last, program completion.
        apply_reset();
        send(4'd7, 5'd7, 5'd5, 5'd4, 16'hABCD, 26'h3FF_FFFF, 1'b0);
        send(4'd8, 5'd3, 5'd3, 5'd3, 16'h5555, 26'h000_0C00, 1'b0);
        send(4'd9, 5'd31, 5'd6, 5'd7, 16'h1111, 26'h2AA_AAAA, 1'b1);
        chk("t36_ready_flush", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 50 && bus.done !== 1'b1; i++) @(negedge clk);
        chk("t36_done", 32'(bus.done), 32'd1);
        chk("t36_words", 32'(bus.words), 32'd3);
        chk("t36_ready_done", 32'(bus.in_ready), 32'd0);
        chk("t36_count", 32'(wq_data.size()), 32'd3);
        if (wq_data.size() >= 3) begin
            chk("t36_d0", wq_data[0], 32'h3C05_ABCD);
            chk("t36_d1", wq_data[1], 32'h0C00_0C00);
            chk("t36_d2", wq_data[2], 32'h03E0_0008);
            chk("t36_a2", wq_addr[2], 32'h3008);
        end

        // Back-pressure: FIFO fills, then drains in order.
        apply_reset();
        bus.wr_busy = 1;
        for (int i = 0; i < 4; i++) send(4'd3, 5'd0, 5'd1, 5'd0, 16'(i + 1), 26'd0, 1'b0);
        bus.in_kind = 4'd3; bus.in_rt = 5'd1; bus.in_imm = 16'd5; bus.in_valid = 1;
        @(negedge clk);
        chk("t37_full_ready0", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t37_full_ready1", 32'(bus.in_ready), 32'd0);
        chk("t37_no_write", 32'(wq_data.size()), 32'd0);
        @(posedge clk); #1;
        bus.wr_busy = 0;
        send(4'd3, 5'd0, 5'd1, 5'd0, 16'd5, 26'd0, 1'b0);
        wait_writes("t37_count", 5);
        for (int i = 0; i < 5; i++)
            if (i < wq_data.size()) chk($sformatf("t37_d%0d", i), wq_data[i], 32'h3401_0000 | 32'(i + 1));

        // Illegal kind between sw and beq.
        apply_reset();
        send(4'd5, 5'd1, 5'd2, 5'd3, 16'h0004, 26'd7, 1'b0);
        send(4'd12, 5'd1, 5'd2, 5'd3, 16'h9999, 26'd7, 1'b0);
        send(4'd6, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'd7, 1'b0);
        wait_writes("t38_count", 2);
        repeat (5) @(negedge clk);
        chk("t38_count_final", 32'(wq_data.size()), 32'd2);
        chk("t38_err", 32'(bus.err), 32'd1);
        if (wq_data.size() >= 2) begin
            chk("t38_d0", wq_data[0], 32'hAC22_0004);
            chk("t38_a0", wq_addr[0], 32'h3000);
            chk("t38_d1", wq_data[1], 32'h1022_FFFF);
            chk("t38_a1", wq_addr[1], 32'h3004);
        end

        // Reset with entries queued discards them.
        apply_reset();
        bus.wr_busy = 1;
        for (int i = 0; i < 3; i++) send(4'd3, 5'd2, 5'd3, 5'd0, 16'h00AA, 26'd0, 1'b0);
        reset = 1;
        bus.wr_busy = 0;
        @(posedge clk);
        #1 reset = 0;
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        repeat (10) @(negedge clk);
        chk("t39_no_write", 32'(wq_data.size()), 32'd0);
        chk("t39_words", 32'(bus.words), 32'd0);
        @(posedge clk); #1;
        send(4'd4, 5'd4, 5'd5, 5'd0, 16'h0010, 26'd0, 1'b0);
        wait_writes("t39_count", 1);
        if (wq_data.size() >= 1) begin
            chk("t39_a0", wq_addr[0], 32'h3000);
            chk("t39_d0", wq_data[0], 32'h8C85_0010);
        end

        // Capacity limit on the IM_WORDS=4 instance.
        apply_reset();
        cnt4 = 0;
        nonzero4 = 0;
        bus4.in_kind = 4'd0;
        bus4.in_rs = 5'd31; bus4.in_rt = 5'd31; bus4.in_imm = 16'hFFFF;
        begin
            int accepted = 0;
            bus4.in_valid = 1;
            for (int i = 0; i < 50 && accepted < 5; i++) begin
                @(negedge clk);
                if (bus4.in_ready === 1'b1) accepted++;
                @(posedge clk);
                #1;
                if (accepted == 5) bus4.in_valid = 0;
            end
            bus4.in_valid = 0;
            chk("t40_accepted", 32'(accepted), 32'd5);
        end
        repeat (20) @(negedge clk);
        chk("t40_writes", 32'(cnt4), 32'd4);
        chk("t40_zero_data", 32'(nonzero4), 32'd0);
        chk("t40_words", 32'(bus4.words), 32'd4);
        chk("t40_err", 32'(bus4.err), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
